// File: rtl/alu_seq.sv
// alu_seq: small sequential ALU with a valid/ready command and result handshake.
// ADD/SUB/XOR/AND/ADDR complete one cycle after accept.
// SHL/SHR shift one bit per cycle; the shift amount is inB[SHW-1:0].
// Optional build macro ALU_SEQ_MUL_EN enables opcode 111 as a W-cycle shift-add multiplier.
// When ALU_SEQ_MUL_EN is not defined, opcode 111 passes operand B through in a single cycle.
module alu_seq #(
    parameter int W   = 8,
    parameter int SHW = $clog2(W)
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rslt,
    output logic         zero,
    output logic         carry,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_r;
    logic [2:0]     cmd_r;
    logic [W-1:0]   rslt_r;
    logic           carry_r;
    logic           zero_r;
    logic [SHW:0]   cnt_r;
`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]   mcand_r;
    logic [W-1:0]   mplier_r;
`endif

    logic [W:0]     sum_s;
    logic [W:0]     diff_s;
    logic [W-1:0]   one_rslt_s;
    logic           one_carry_s;
    logic           start_exec_s;
    logic [SHW-1:0] shamt_s;
    logic [W-1:0]   exec_rslt_s;
    logic           exec_carry_s;

    assign shamt_s = inB[SHW-1:0];
    assign sum_s   = {1'b0, inA} + {1'b0, inB};
    assign diff_s  = {1'b0, inA} - {1'b0, inB};

    // Result of every op that finishes on the accept edge, plus whether the op needs EXEC.
    always_comb begin
        one_rslt_s   = {W{1'b0}};
        one_carry_s  = 1'b0;
        start_exec_s = 1'b0;
        case (alu_cmd)
            3'b000: begin
                one_rslt_s  = sum_s[W-1:0];
                one_carry_s = sum_s[W];
            end
            3'b001: begin
                one_rslt_s  = diff_s[W-1:0];
                one_carry_s = diff_s[W];
            end
            3'b010: one_rslt_s = inA ^ inB;
            3'b011: one_rslt_s = inA & inB;
            3'b100, 3'b101: begin
                // A zero shift amount completes immediately with A unchanged.
                one_rslt_s   = inA;
                start_exec_s = (shamt_s != {SHW{1'b0}});
            end
            3'b110: one_rslt_s = sum_s[W-1:0];
            3'b111: begin
`ifdef ALU_SEQ_MUL_EN
                start_exec_s = 1'b1;
`else
                one_rslt_s = inB;
`endif
            end
            default: one_rslt_s = {W{1'b0}};
        endcase
    end

    // Next working value and carry for one EXEC step of the captured op.
    always_comb begin
        exec_rslt_s  = rslt_r;
        exec_carry_s = carry_r;
        case (cmd_r)
            3'b100: begin
                exec_rslt_s  = {rslt_r[W-2:0], 1'b0};
                exec_carry_s = rslt_r[W-1];
            end
            3'b101: begin
                exec_rslt_s  = {1'b0, rslt_r[W-1:1]};
                exec_carry_s = rslt_r[0];
            end
`ifdef ALU_SEQ_MUL_EN
            3'b111: begin
                if (mplier_r[0]) begin
                    exec_rslt_s = rslt_r + mcand_r;
                end else begin
                    exec_rslt_s = rslt_r;
                end
                exec_carry_s = 1'b0;
            end
`endif
            default: begin
                exec_rslt_s  = rslt_r;
                exec_carry_s = carry_r;
            end
        endcase
    end

    // Control FSM and result datapath; reset wins over everything including accept.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r  <= IDLE;
            cmd_r    <= 3'b000;
            rslt_r   <= {W{1'b0}};
            carry_r  <= 1'b0;
            zero_r   <= 1'b0;
            cnt_r    <= {(SHW+1){1'b0}};
`ifdef ALU_SEQ_MUL_EN
            mcand_r  <= {W{1'b0}};
            mplier_r <= {W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        cmd_r <= alu_cmd;
                        if (start_exec_s) begin
                            state_r <= EXEC;
                            carry_r <= 1'b0;
                            zero_r  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                            if (alu_cmd == 3'b111) begin
                                rslt_r   <= {W{1'b0}};
                                mcand_r  <= inA;
                                mplier_r <= inB;
                                cnt_r    <= (SHW+1)'(W);
                            end else begin
                                rslt_r <= inA;
                                cnt_r  <= {1'b0, shamt_s};
                            end
`else
                            rslt_r <= inA;
                            cnt_r  <= {1'b0, shamt_s};
`endif
                        end else begin
                            state_r <= DONE;
                            rslt_r  <= one_rslt_s;
                            carry_r <= one_carry_s;
                            zero_r  <= (one_rslt_s == {W{1'b0}});
                        end
                    end
                end
                EXEC: begin
                    rslt_r  <= exec_rslt_s;
                    carry_r <= exec_carry_s;
                    cnt_r   <= cnt_r - (SHW+1)'(1);
`ifdef ALU_SEQ_MUL_EN
                    mcand_r  <= {mcand_r[W-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[W-1:1]};
`endif
                    if (cnt_r == (SHW+1)'(1)) begin
                        state_r <= DONE;
                        zero_r  <= (exec_rslt_s == {W{1'b0}});
                    end else begin
                        zero_r  <= 1'b0;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it.
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r == EXEC);
    assign out_valid = (state_r == DONE);
    assign rslt      = rslt_r;
    assign zero      = zero_r;
    assign carry     = carry_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (W = 8) with hand-computed expected values.
module tb_alu_seq;

    localparam int W = 8;

    logic         Clk;
    logic         Reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alu_cmd;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] rslt;
    logic         zero;
    logic         carry;
    logic         busy;

    int errors = 0;
    int checks = 0;

    alu_seq #(.W(W)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_cmd  (alu_cmd),
        .inA      (inA),
        .inB      (inB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rslt     (rslt),
        .zero     (zero),
        .carry    (carry),
        .busy     (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one command for one edge, then scramble the inputs.
    task automatic issue(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        alu_cmd  = c;
        inA      = a;
        inB      = b;
        tick();
        in_valid = 1'b0;
        alu_cmd  = ~c;
        inA      = 8'h5C;
        inB      = 8'hA7;
    endtask

    // Wait for out_valid; cyc is the cycle index after accept, bsy counts EXEC cycles.
    task automatic wait_done(output int cyc, output int bsy);
        cyc = 1;
        bsy = 0;
        while (out_valid !== 1'b1 && cyc < 64) begin
            if (busy === 1'b1) bsy++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] c, input logic [7:0] a,
                          input logic [7:0] b, input int lat, input logic [7:0] er,
                          input logic ez, input logic ec);
        int cyc;
        int bsy;
        issue(c, a, b);
        wait_done(cyc, bsy);
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " busy"}, bsy, lat - 1);
        chk({tag, " rslt"}, rslt, er);
        chk({tag, " zero"}, zero, ez);
        chk({tag, " carry"}, carry, ec);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, out_valid, 1'b0);
        chk({tag, " in_ready back"}, in_ready, 1'b1);
    endtask

    initial begin
        int cyc;
        int bsy;
        int seen;
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_cmd   = 3'b000;
        inA       = 8'h00;
        inB       = 8'h00;
        tick();
        tick();
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst rslt", rslt, 8'h00);
        chk("rst zero", zero, 1'b0);
        chk("rst carry", carry, 1'b0);
        Reset_n = 1'b1;
        tick();

        run_op("add ff+01", 3'b000, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1);
        run_op("sub 03-05", 3'b001, 8'h03, 8'h05, 1, 8'hFE, 1'b0, 1'b1);
        run_op("sub 05-05", 3'b001, 8'h05, 8'h05, 1, 8'h00, 1'b1, 1'b0);
        run_op("xor",       3'b010, 8'h0F, 8'hFF, 1, 8'hF0, 1'b0, 1'b0);
        run_op("and",       3'b011, 8'h3C, 8'h0F, 1, 8'h0C, 1'b0, 1'b0);
        run_op("addr",      3'b110, 8'hFF, 8'h02, 1, 8'h01, 1'b0, 1'b0);
        run_op("shl 81<<3", 3'b100, 8'h81, 8'h03, 4, 8'h08, 1'b0, 1'b0);
        run_op("shr 03>>1", 3'b101, 8'h03, 8'h01, 2, 8'h01, 1'b0, 1'b1);
        run_op("shl k0",    3'b100, 8'h5A, 8'h08, 1, 8'h5A, 1'b0, 1'b0);
        run_op("shr 80>>7", 3'b101, 8'h80, 8'h07, 8, 8'h01, 1'b0, 1'b0);
        run_op("shl c0<<2", 3'b100, 8'hC0, 8'h02, 3, 8'h00, 1'b1, 1'b1);
`ifdef ALU_SEQ_MUL_EN
        run_op("mul 0d*0b", 3'b111, 8'h0D, 8'h0B, 9, 8'h8F, 1'b0, 1'b0);
        run_op("mul ff*ff", 3'b111, 8'hFF, 8'hFF, 9, 8'h01, 1'b0, 1'b0);
`else
        run_op("mul 0d*0b", 3'b111, 8'h0D, 8'h0B, 1, 8'h0B, 1'b0, 1'b0);
        run_op("mul ff*ff", 3'b111, 8'hFF, 8'hFF, 1, 8'hFF, 1'b0, 1'b0);
`endif

        // Hold DONE with out_ready low while a new command is offered.
        issue(3'b000, 8'h10, 8'h20);
        wait_done(cyc, bsy);
        chk("hold latency", cyc, 1);
        in_valid = 1'b1;
        alu_cmd  = 3'b010;
        inA      = 8'hFF;
        inB      = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            chk("hold rslt", rslt, 8'h30);
            chk("hold in_ready", in_ready, 1'b0);
            chk("hold out_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release out_valid", out_valid, 1'b0);
        chk("release in_ready", in_ready, 1'b1);
        tick();
        chk("no late accept", out_valid, 1'b0);
        chk("no late accept busy", busy, 1'b0);

        // Reset in the 2nd EXEC cycle of SHL by 5 aborts the op.
        issue(3'b100, 8'hFF, 8'h05);
        chk("abort exec1 busy", busy, 1'b1);
        tick();
        chk("abort exec2 busy", busy, 1'b1);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        chk("abort out_valid", out_valid, 1'b0);
        chk("abort rslt", rslt, 8'h00);
        chk("abort in_ready", in_ready, 1'b1);
        chk("abort busy", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        chk("abort no result", seen, 0);

        // Reset wins over an accept in the same cycle.
        Reset_n  = 1'b0;
        in_valid = 1'b1;
        alu_cmd  = 3'b000;
        inA      = 8'h01;
        inB      = 8'h01;
        tick();
        in_valid = 1'b0;
        Reset_n  = 1'b1;
        chk("rst prio out_valid", out_valid, 1'b0);
        chk("rst prio in_ready", in_ready, 1'b1);
        chk("rst prio rslt", rslt, 8'h00);

        // Block still works after the reset.
        run_op("post-rst add", 3'b000, 8'h10, 8'h20, 1, 8'h30, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
